psa_search_sched: RTL and testbench
===================================

Name: psa_search_sched

Overview:
- Job scheduler in front of the `search` pattern-search engine.
- Accepts search jobs (pattern address/length, block address/length, tag) over a valid/ready command port and queues them in a small FIFO.
- Runs the jobs one at a time: loads the engine inputs, pulses the engine reset, holds activate until done or timeout, then returns a tagged result over a valid/ready response port.

Parameters:
- CMD_DEPTH, 4, command FIFO depth (power of two, ≥2)
- TIMEOUT_CYCLES, 1048576, max cycles in RUN before the job is abandoned
- RST_CYCLES, 2, cycles eng_reset is held high per job
- NOT_FOUND, 15'h00FF, engine found value meaning no match

Ports:
- CLK100MHZ  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  job offered
- cmd_ready  out  1  FIFO not full
- cmd_p  in  8  pattern address
- cmd_pl  in  8  pattern length
- cmd_b  in  8  block address
- cmd_bl  in  15  block length
- cmd_tag  in  4  job ID, echoed in response
- eng_reset  out  1  to search.reset
- eng_activate  out  1  to search.activate
- eng_p / eng_pl / eng_b  out  8 each  to search p/pl/b
- eng_bl  out  15  to search bl
- eng_done  in  1  from search.done
- eng_found  in  15  from search.found
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts
- rsp_tag  out  4  job ID
- rsp_found  out  15  match address (NOT_FOUND if none)
- rsp_hit  out  1  eng_found != NOT_FOUND and not timeout
- rsp_timeout  out  1  job abandoned
- busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, active-high): FIFO empty; state=IDLE; cmd_ready=1; eng_reset=1 (engine kept cleared); eng_activate=0; eng_* inputs=0; rsp_valid=0; rsp_tag/found=0; rsp_hit/timeout=0.
- FIFO: push when cmd_valid&&cmd_ready; pop only in IDLE when non-empty. Push and pop in the same cycle are allowed, with count unchanged. A push into a full FIFO cannot happen because cmd_ready=0. Pointers wrap modulo CMD_DEPTH.
- IDLE: eng_reset=1, eng_activate=0. If FIFO non-empty: pop, latch job into eng_p/pl/b/bl and tag register, go to CLEAR.
- CLEAR: eng_reset=1 for RST_CYCLES cycles, counted by rcnt. eng_* inputs are stable throughout. Then deassert eng_reset, clear cycle counter tcnt=0, go to RUN.
- RUN: eng_activate=1.
  - tcnt increments each cycle and saturates.
  - If eng_done=1: capture eng_found, go to RESP with timeout=0.
  - Else if tcnt==TIMEOUT_CYCLES-1: go to RESP with timeout=1, rsp_found=NOT_FOUND.
  - If both happen in the same cycle, eng_done wins.
- RESP: eng_activate=0, eng_reset=1. rsp_valid=1 with fields stable until rsp_ready. On the handshake cycle go to IDLE. A new job launches no earlier than the cycle after IDLE is entered.
- Latency: with an idle queue, a job's first eng_activate cycle comes 1+RST_CYCLES cycles after the cmd handshake.
- Degenerate jobs: pl==0 or bl==0 produce an immediate RESP (from IDLE, skipping CLEAR/RUN) with rsp_found=NOT_FOUND, rsp_hit=0, rsp_timeout=0.
- eng_* inputs and eng_activate are registered outputs, glitch-free. eng_reset is registered and drives the engine's async reset.
- Reset mid-job: everything returns to reset values immediately; the in-flight job and queued jobs are dropped with no response.
- States are one-hot: IDLE, CLEAR, RUN, RESP. An illegal state goes to IDLE.

Decomposition:
- Shared package/header:
  - state encodings (one-hot localparams)
  - NOT_FOUND default
  - job field widths (ADDR_W=8, LEN_W=15, TAG_W=4)
  - job word width = 8+8+8+15+4 = 43
- Sub-module psa_cmd_fifo: synchronous FIFO with async reset, parameterised width/depth, outputs full/empty/count.

Test Plan:
- One job (p=0, pl=3, b=0, bl=250, tag=5); engine model asserts done after 40 cycles with found=15'd17 → rsp_valid with tag=5, found=17, hit=1, timeout=0; first activate exactly 1+RST_CYCLES cycles after cmd handshake.
- Engine model returns found=15'h00FF → rsp_hit=0, rsp_found=15'h00FF, rsp_timeout=0.
- Push 5 jobs back-to-back with CMD_DEPTH=4 and rsp_ready=1 → cmd_ready drops when full; all 5 responses arrive in tag order 0..4; eng_reset pulses ≥RST_CYCLES between jobs.
- TIMEOUT_CYCLES=64, engine never asserts done → response after 64 RUN cycles with timeout=1, hit=0, found=15'h00FF; next queued job then runs.
- rsp_ready held low 20 cycles → rsp fields stable, no new job launched, eng_activate=0; release → IDLE, next job starts.
- Assert reset mid-RUN with 2 jobs queued → outputs return to reset values the same cycle; no responses emitted; busy=0 after reset release.

Source files
------------

// File: rtl/psa_search_sched_pkg.sv
// Shared types and constants for the search-engine job scheduler.
// Job word layout, one-hot FSM encodings and the "no match" sentinel.
package psa_search_sched_pkg;

  localparam int ADDR_W = 8;
  localparam int LEN_W  = 15;
  localparam int TAG_W  = 4;
  localparam int JOB_W  = 3 * ADDR_W + LEN_W + TAG_W;

  localparam logic [LEN_W-1:0] NOT_FOUND_DEF = 15'h00FF;

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_CLEAR = 4'b0010;
  localparam logic [3:0] ST_RUN   = 4'b0100;
  localparam logic [3:0] ST_RESP  = 4'b1000;

  typedef enum logic [3:0] {
    IDLE  = ST_IDLE,
    CLEAR = ST_CLEAR,
    RUN   = ST_RUN,
    RESP  = ST_RESP
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] p;
    logic [ADDR_W-1:0] pl;
    logic [ADDR_W-1:0] b;
    logic [LEN_W-1:0]  bl;
    logic [TAG_W-1:0]  tag;
  } job_t;

  // Empty pattern or empty block: nothing for the engine to search.
  function automatic logic is_degenerate(input job_t j);
    return (j.pl == '0) || (j.bl == '0);
  endfunction

endpackage

// File: rtl/psa_search_sched_if.sv
// Command and response channels of the scheduler.
// Both channels: a beat transfers on a rising edge where valid && ready; the
// sender keeps valid and its fields stable until that edge, ready may toggle freely.
interface psa_search_sched_if;
  import psa_search_sched_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_p;
  logic [ADDR_W-1:0] cmd_pl;
  logic [ADDR_W-1:0] cmd_b;
  logic [LEN_W-1:0]  cmd_bl;
  logic [TAG_W-1:0]  cmd_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [TAG_W-1:0]  rsp_tag;
  logic [LEN_W-1:0]  rsp_found;
  logic              rsp_hit;
  logic              rsp_timeout;

  modport master (
    output cmd_valid, cmd_p, cmd_pl, cmd_b, cmd_bl, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_tag, rsp_found, rsp_hit, rsp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_p, cmd_pl, cmd_b, cmd_bl, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_tag, rsp_found, rsp_hit, rsp_timeout
  );

endinterface

// File: rtl/psa_search_sched_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO with asynchronous reset.
// Pushes into a full FIFO and pops from an empty one are ignored.
module psa_cmd_fifo #(
    parameter int W     = 43,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/psa_search_sched.sv
// Job scheduler for the search engine: queues jobs, runs them one at a time
// (clear, run until done/timeout) and returns a tagged result.
module psa_search_sched
    import psa_search_sched_pkg::*;
#(
    parameter int               CMD_DEPTH      = 4,
    parameter int               TIMEOUT_CYCLES = 1048576,
    parameter int               RST_CYCLES     = 2,
    parameter logic [LEN_W-1:0] NOT_FOUND      = NOT_FOUND_DEF
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    psa_search_sched_if.slave host,
    output logic              eng_reset,
    output logic              eng_activate,
    output logic [ADDR_W-1:0] eng_p,
    output logic [ADDR_W-1:0] eng_pl,
    output logic [ADDR_W-1:0] eng_b,
    output logic [LEN_W-1:0]  eng_bl,
    input  logic              eng_done,
    input  logic [LEN_W-1:0]  eng_found,
    output logic              busy,
    output logic [3:0]        dbg_state
);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RCNT_W = $clog2(RST_CYCLES + 1);
    localparam int FCNT_W = $clog2(CMD_DEPTH) + 1;

    state_e             state_q, state_d;
    job_t               job_q, job_d;
    logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic               eng_reset_q, eng_reset_d;
    logic               eng_act_q, eng_act_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic [LEN_W-1:0]   rsp_found_q, rsp_found_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic               rsp_timeout_q, rsp_timeout_d;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FCNT_W-1:0]  fifo_count;
    job_t               fifo_wdata, fifo_rdata;

    assign fifo_wdata = '{p: host.cmd_p, pl: host.cmd_pl, b: host.cmd_b,
                          bl: host.cmd_bl, tag: host.cmd_tag};
    assign fifo_push  = host.cmd_valid && host.cmd_ready;

    psa_cmd_fifo #(.W(JOB_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (CLK100MHZ),
        .rst   (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        job_d         = job_q;
        rcnt_d        = rcnt_q;
        tcnt_d        = tcnt_q;
        eng_reset_d   = eng_reset_q;
        eng_act_d     = eng_act_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_found_d   = rsp_found_q;
        rsp_hit_d     = rsp_hit_q;
        rsp_timeout_d = rsp_timeout_q;
        fifo_pop      = 1'b0;

        case (state_q)
            IDLE: begin
                eng_reset_d = 1'b1;
                eng_act_d   = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    job_d    = fifo_rdata;
                    if (is_degenerate(fifo_rdata)) begin
                        state_d       = RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_tag_d     = fifo_rdata.tag;
                        rsp_found_d   = NOT_FOUND;
                        rsp_hit_d     = 1'b0;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        state_d = CLEAR;
                        rcnt_d  = '0;
                    end
                end
            end

            CLEAR: begin
                if (rcnt_q == RCNT_W'(RST_CYCLES - 1)) begin
                    state_d     = RUN;
                    eng_reset_d = 1'b0;
                    eng_act_d   = 1'b1;
                    tcnt_d      = '0;
                end else begin
                    rcnt_d = rcnt_q + RCNT_W'(1);
                end
            end

            // Done has priority over the timeout on the same cycle.
            RUN: begin
                if (eng_done) begin
                    state_d       = RESP;
                    eng_act_d     = 1'b0;
                    eng_reset_d   = 1'b1;
                    rsp_valid_d   = 1'b1;
                    rsp_tag_d     = job_q.tag;
                    rsp_found_d   = eng_found;
                    rsp_hit_d     = (eng_found != NOT_FOUND);
                    rsp_timeout_d = 1'b0;
                end else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = RESP;
                    eng_act_d     = 1'b0;
                    eng_reset_d   = 1'b1;
                    rsp_valid_d   = 1'b1;
                    rsp_tag_d     = job_q.tag;
                    rsp_found_d   = NOT_FOUND;
                    rsp_hit_d     = 1'b0;
                    rsp_timeout_d = 1'b1;
                end else if (tcnt_q != {TCNT_W{1'b1}}) begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end

            RESP: begin
                eng_act_d   = 1'b0;
                eng_reset_d = 1'b1;
                if (host.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                eng_act_d   = 1'b0;
                eng_reset_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            job_q         <= '0;
            rcnt_q        <= '0;
            tcnt_q        <= '0;
            eng_reset_q   <= 1'b1;
            eng_act_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_tag_q     <= '0;
            rsp_found_q   <= '0;
            rsp_hit_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            job_q         <= job_d;
            rcnt_q        <= rcnt_d;
            tcnt_q        <= tcnt_d;
            eng_reset_q   <= eng_reset_d;
            eng_act_q     <= eng_act_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_found_q   <= rsp_found_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign host.cmd_ready   = !fifo_full;
    assign host.rsp_valid   = rsp_valid_q;
    assign host.rsp_tag     = rsp_tag_q;
    assign host.rsp_found   = rsp_found_q;
    assign host.rsp_hit     = rsp_hit_q;
    assign host.rsp_timeout = rsp_timeout_q;

    assign eng_reset    = eng_reset_q;
    assign eng_activate = eng_act_q;
    assign eng_p        = job_q.p;
    assign eng_pl       = job_q.pl;
    assign eng_b        = job_q.b;
    assign eng_bl       = job_q.bl;

    assign busy      = (state_q != IDLE) || (fifo_count != '0);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_psa_search_sched.sv
// Directed bench for psa_search_sched with a behavioural engine model and a
// response scoreboard keyed on {tag, found, hit, timeout}.
module tb_psa_search_sched;
  import psa_search_sched_pkg::*;

  localparam int          RST_CYC = 2;
  localparam int          TMO     = 64;
  localparam logic [14:0] NF      = 15'h00FF;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  psa_search_sched_if bus();

  logic        eng_reset, eng_activate, busy;
  logic [7:0]  eng_p, eng_pl, eng_b;
  logic [14:0] eng_bl;
  logic        eng_done = 1'b0;
  logic [14:0] eng_found = '0;
  logic [3:0]  dbg_state;

  psa_search_sched #(
    .CMD_DEPTH(4), .TIMEOUT_CYCLES(TMO), .RST_CYCLES(RST_CYC), .NOT_FOUND(NF)
  ) dut (
    .CLK100MHZ    (clk),
    .reset        (reset),
    .host         (bus),
    .eng_reset    (eng_reset),
    .eng_activate (eng_activate),
    .eng_p        (eng_p),
    .eng_pl       (eng_pl),
    .eng_b        (eng_b),
    .eng_bl       (eng_bl),
    .eng_done     (eng_done),
    .eng_found    (eng_found),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [20:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // engine model: done after done_after activate cycles (0 = never)
  int          done_after = 0;
  logic [14:0] found_val  = '0;
  int          act_cnt    = 0;
  always @(posedge clk) begin
    if (eng_reset) begin
      act_cnt  <= 0;
      eng_done <= 1'b0;
    end else if (eng_activate) begin
      act_cnt <= act_cnt + 1;
      if (done_after != 0 && act_cnt + 1 == done_after) begin
        eng_done  <= 1'b1;
        eng_found <= found_val;
      end
    end
  end

  // monitor + scoreboard
  int   rst_run = 0, act_run = 0, last_act = 0, total_act = 0, rsp_count = 0;
  logic prev_eng_reset = 1'b1;
  always @(negedge clk) begin
    if (eng_reset) rst_run++;
    else begin
      if (prev_eng_reset) check("eng_reset_len", 64'(rst_run >= RST_CYC), 1);
      rst_run = 0;
    end
    prev_eng_reset = eng_reset;
    if (eng_activate) begin
      act_run++;
      total_act++;
    end else if (act_run != 0) begin
      last_act = act_run;
      act_run  = 0;
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      rsp_count++;
      if (exp_q.size() == 0) check("unexpected_rsp", {bus.rsp_tag, bus.rsp_found, bus.rsp_hit, bus.rsp_timeout}, 0);
      else begin
        check("rsp", {bus.rsp_tag, bus.rsp_found, bus.rsp_hit, bus.rsp_timeout}, exp_q.pop_front());
        if (bus.rsp_timeout) check("timeout_run_len", last_act, TMO);
      end
    end
  end

  // driver tasks
  task automatic push_exp(input logic [3:0] tag, input logic [14:0] found, input logic hit, input logic to);
    exp_q.push_back({tag, found, hit, to});
  endtask

  task automatic send_cmd(input logic [7:0] p, input logic [7:0] pl, input logic [7:0] b,
                          input logic [14:0] bl, input logic [3:0] tag);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_p = p; bus.cmd_pl = pl; bus.cmd_b = b; bus.cmd_bl = bl; bus.cmd_tag = tag;
    while (!bus.cmd_ready && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check("cmd_accept_bound", 64'(n < 500), 1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
      @(posedge clk); #1; n++;
    end
    check(name, 64'(n < max_cyc), 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_cmd_ready"}, bus.cmd_ready, 1);
    check({name, "_eng_reset"}, eng_reset, 1);
    check({name, "_eng_act"}, eng_activate, 0);
    check({name, "_eng_in"}, {eng_p, eng_pl, eng_b, eng_bl}, 0);
    check({name, "_rsp_valid"}, bus.rsp_valid, 0);
    check({name, "_rsp_fields"}, {bus.rsp_tag, bus.rsp_found, bus.rsp_hit, bus.rsp_timeout}, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int act_before;
    logic [20:0] snap;
    int changes, act_seen;

    bus.cmd_valid = 1'b0; bus.cmd_p = '0; bus.cmd_pl = '0; bus.cmd_b = '0;
    bus.cmd_bl = '0; bus.cmd_tag = '0; bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // single job, hit, plus launch latency
    done_after = 40; found_val = 15'd17;
    push_exp(4'd5, 15'd17, 1'b1, 1'b0);
    send_cmd(8'd0, 8'd3, 8'd0, 15'd250, 4'd5);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!eng_activate && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("first_act_latency", n, 1 + RST_CYC);
    check("run_eng_reset", eng_reset, 0);
    check("run_eng_inputs", {eng_p, eng_pl, eng_b, eng_bl}, {8'd0, 8'd3, 8'd0, 15'd250});
    drain("drain_single", 500);

    // engine reports the no-match value
    done_after = 10; found_val = NF;
    push_exp(4'd1, NF, 1'b0, 1'b0);
    send_cmd(8'd4, 8'd2, 8'd9, 15'd30, 4'd1);
    bus.cmd_valid = 1'b0;
    drain("drain_nomatch", 500);

    // five back-to-back jobs into a depth-4 queue
    done_after = 5; found_val = 15'd33;
    for (int t = 0; t < 5; t++) push_exp(4'(t), 15'd33, 1'b1, 1'b0);
    for (int t = 0; t < 5; t++) send_cmd(8'(t), 8'd2, 8'(t + 16), 15'd100, 4'(t));
    check("full_after_burst", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b0;
    drain("drain_burst", 1000);

    // two jobs that time out
    done_after = 0;
    push_exp(4'd8, NF, 1'b0, 1'b1);
    push_exp(4'd9, NF, 1'b0, 1'b1);
    send_cmd(8'd1, 8'd1, 8'd1, 15'd1000, 4'd8);
    send_cmd(8'd2, 8'd1, 8'd1, 15'd1000, 4'd9);
    bus.cmd_valid = 1'b0;
    drain("drain_timeout", 500);

    // response back-pressure
    done_after = 5; found_val = 15'd100;
    bus.rsp_ready = 1'b0;
    push_exp(4'd6, 15'd100, 1'b1, 1'b0);
    push_exp(4'd7, 15'd100, 1'b1, 1'b0);
    send_cmd(8'd3, 8'd4, 8'd5, 15'd60, 4'd6);
    send_cmd(8'd3, 8'd4, 8'd5, 15'd60, 4'd7);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("hold_rsp_arrives", 64'(n < 100), 1);
    snap = {bus.rsp_tag, bus.rsp_found, bus.rsp_hit, bus.rsp_timeout};
    changes = 0; act_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!bus.rsp_valid || {bus.rsp_tag, bus.rsp_found, bus.rsp_hit, bus.rsp_timeout} != snap) changes++;
      if (eng_activate) act_seen++;
    end
    check("hold_fields_stable", changes, 0);
    check("hold_no_activate", act_seen, 0);
    check("hold_state_resp", dbg_state, ST_RESP);
    check("hold_snapshot", snap, {4'd6, 15'd100, 1'b1, 1'b0});
    bus.rsp_ready = 1'b1;
    drain("drain_hold", 500);

    // degenerate jobs never reach the engine
    act_before = total_act;
    push_exp(4'd10, NF, 1'b0, 1'b0);
    push_exp(4'd11, NF, 1'b0, 1'b0);
    send_cmd(8'd1, 8'd0, 8'd2, 15'd9, 4'd10);
    send_cmd(8'd1, 8'd2, 8'd2, 15'd0, 4'd11);
    bus.cmd_valid = 1'b0;
    drain("drain_degenerate", 200);
    check("degenerate_no_activate", total_act - act_before, 0);

    // reset while running with two jobs queued
    done_after = 0;
    send_cmd(8'd7, 8'd2, 8'd7, 15'd50, 4'd12);
    send_cmd(8'd7, 8'd2, 8'd7, 15'd50, 4'd13);
    send_cmd(8'd7, 8'd2, 8'd7, 15'd50, 4'd14);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (dbg_state != ST_RUN && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("midrun_reached_run", dbg_state, ST_RUN);
    n = rsp_count;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrun_reset");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("post_reset_busy", busy, 0);
    check("post_reset_no_rsp", rsp_count - n, 0);
    check("post_reset_state", dbg_state, ST_IDLE);

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
